level_select_ctrl: RTL and testbench
====================================

# level_select_ctrl

Debounced level-selection controller for the Whack-A-Mole switch bank. It synchronizes the difficulty switches and detects any rising or falling change on them. It then filters bounce, arbitrates between simultaneously set switches by priority, and commits the new game level only while the game FSM is not busy. The game core consumes its registered `level` output and its one-cycle `level_update` pulse.

## Interface
- `N_SW`, default 4: number of level switches.
- `DEB_CYCLES`, default 16: consecutive stable cycles required before a change is accepted; legal range is 2 or more.
- `LEVEL_W`, default 3: width of `level`; must be at least $clog2(N_SW+1).
- `clk` input, 1 bit: the single system clock.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `sw` input, N_SW bits: raw level switches, asynchronous to `clk`.
- `game_busy` input, 1 bit: high while a round is in progress, during which level changes are not allowed.
- `level` output, LEVEL_W bits: current committed level, registered.
- `level_update` output, 1 bit: one-cycle pulse, high in the cycle in which `level` first shows a new commit.
- `pending` output, 1 bit: high while a debounced change is waiting for `game_busy` to drop.

## Operation
- **Synchronizer:** a two-flop synchronizer on `sw` produces `s`. All logic uses `s` only.
- **Registers:**
  - `stable`: last committed switch vector.
  - `cand`: candidate vector.
  - `cnt`: debounce counter, $clog2(DEB_CYCLES) bits.
- **Change detect:** any bit where `s` differs from `stable` counts as a change, in either direction.
- **FSM states:** IDLE, DEBOUNCE, WAIT_IDLE, COMMIT.
  - **IDLE:** if `s` != `stable`, then `cand` <= `s`, `cnt` <= 0, and the FSM goes to DEBOUNCE.
  - **DEBOUNCE:** if `s` != `cand`, then `cand` <= `s` and `cnt` <= 0 (restart). Otherwise, when `cnt` == DEB_CYCLES-1:
    - if `cand` == `stable` (the input bounced back), go to IDLE with no update;
    - else if `game_busy` is high, go to WAIT_IDLE;
    - else go to COMMIT.
  - Otherwise in DEBOUNCE, `cnt` <= `cnt`+1.
  - **WAIT_IDLE:** `pending` is 1. If `s` != `cand`, then `cand` <= `s`, `cnt` <= 0, and the FSM goes to DEBOUNCE. Otherwise, when `game_busy` is low, go to COMMIT.
  - **COMMIT:** lasts exactly one cycle, with `level_update` = 1. Then go to IDLE.
- **Commit loading:** `stable` <= `cand` and `level` <= enc(`cand`) load on the clock edge that enters COMMIT.
- **Priority encode:** enc(v) = (index of the highest set bit) + 1, or 0 if v == 0. For example, 4'b1011 gives 4 and 4'b0011 gives 2.
- **Output decode:** `level_update` and `pending` are decoded from the state register, so they have no combinational path from the inputs.
- **Reset:** asynchronous, affecting all flops.
  - State returns to IDLE.
  - Synchronizer, `stable`, `cand`, `cnt`, `level`, `level_update` and `pending` are all cleared to 0.
  - After release, switches that are already on count as a change and are committed normally.

## Timing
- Edge 0 is the first edge that samples a new `sw` value.
  - Edge 1: `s` is valid.
  - Edge 2: the FSM enters DEBOUNCE.
  - Edge DEB_CYCLES+2: the FSM enters COMMIT, provided the input is stable and `game_busy` is low.
  - `level_update` is high for the cycle after edge DEB_CYCLES+2. With DEB_CYCLES=16, that is edge 18.
- Pulses on `s` shorter than DEB_CYCLES cycles never reach COMMIT.
- From WAIT_IDLE, COMMIT is entered on the first edge that samples `game_busy` = 0.
- `level_update` is never high on two consecutive cycles.
- The minimum spacing between two pulses is DEB_CYCLES+2 cycles.
- `game_busy` is sampled only in DEBOUNCE (at terminal count) and in WAIT_IDLE.
- A rise of `game_busy` in the same cycle as COMMIT does not cancel the commit.

## Configuration
- **`LEVEL_LOCK_EN` defined:**
  - A debounced change that finds `game_busy` high at terminal count is discarded.
  - `stable` <= `cand`, so the same position does not re-trigger, and the FSM goes to IDLE.
  - `level` is unchanged, no pulse is issued, and WAIT_IDLE is unreachable, so `pending` is constant 0.
- **`LEVEL_LOCK_EN` not defined (default):** the change is deferred in WAIT_IDLE as described above.

## Test plan
- **Reset values:** `reset`=1 with `sw`=4'b0101 → `level`=0, `level_update`=0 and `pending`=0 throughout. After release with `game_busy`=0 → `level`=3 and a single pulse at edge 18.
- **Clean change:** from stable 0, set `sw`=4'b0100 with `game_busy`=0 → exactly one `level_update` pulse after edge 18 and `level`=3. No further pulses while `sw` is held.
- **Bounce rejection:**
  - A 3-cycle glitch on `sw[0]` from stable 0 → no pulse, `level` stays 0, FSM returns to IDLE.
  - Toggle `sw[1]` every 5 cycles for 40 cycles, then hold it at 1 → one pulse, 18 edges after the final toggle, with `level`=2.
- **Priority:** `sw`=4'b1011 → `level`=4; then `sw`=4'b0011 → `level`=2, one pulse per change. `sw`=4'b0000 → `level`=0.
- **Busy deferral:** `game_busy`=1, change `sw` to 4'b0010 → `pending`=1 after edge 18 and no pulse. Drop `game_busy` → pulse one cycle later with `level`=2 and `pending`=0.
  - Under `LEVEL_LOCK_EN`: `pending` is always 0, no pulse occurs, and `level` is unchanged after `game_busy` drops.
- **Reset mid-operation:** assert `reset` at `cnt`=7 in DEBOUNCE → all outputs are 0 in the same cycle (asynchronous), and the FSM is in IDLE after release.

Source files
------------

// File: rtl/level_select_ctrl.sv
// Debounced level-selection controller: syncs the switch bank, filters bounce,
// priority-encodes the winner and commits it while the game is idle. Option: LEVEL_LOCK_EN.
module level_select_ctrl #(
  parameter int unsigned N_SW       = 4,
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned LEVEL_W    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_SW-1:0]    sw,
  input  logic               game_busy,
  output logic [LEVEL_W-1:0] level,
  output logic               level_update,
  output logic               pending
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEBOUNCE  = 2'd1,
    WAIT_IDLE = 2'd2,
    COMMIT    = 2'd3
  } state_t;

  state_t            state;
  logic [N_SW-1:0]   sync1;
  logic [N_SW-1:0]   s;
  logic [N_SW-1:0]   stable;
  logic [N_SW-1:0]   cand;
  logic [CNT_W-1:0]  cnt;
  logic              term;

  // Highest set bit wins; level is its index plus one, zero when nothing is set.
  function automatic logic [LEVEL_W-1:0] enc(input logic [N_SW-1:0] v);
    logic [LEVEL_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(N_SW); i++) begin
      if (v[i]) r = LEVEL_W'(i + 1);
    end
    return r;
  endfunction

  assign term = (cnt == CNT_W'(DEB_CYCLES - 1));

  // Two-flop synchronizer for the asynchronous switch bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= sw;
      s     <= sync1;
    end
  end

  // Control FSM; level_update/pending are flops that track COMMIT/WAIT_IDLE entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      stable       <= '0;
      cand         <= '0;
      cnt          <= '0;
      level        <= '0;
      level_update <= 1'b0;
      pending      <= 1'b0;
    end else begin
      level_update <= 1'b0;
      pending      <= 1'b0;
      case (state)
        IDLE: begin
          if (s != stable) begin
            cand  <= s;
            cnt   <= '0;
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (s != cand) begin
            cand <= s;
            cnt  <= '0;
          end else if (term) begin
            if (cand == stable) begin
              state <= IDLE;
            end else if (game_busy) begin
`ifdef LEVEL_LOCK_EN
              // Locked: swallow the change so the same position does not re-arm.
              stable <= cand;
              state  <= IDLE;
`else
              pending <= 1'b1;
              state   <= WAIT_IDLE;
`endif
            end else begin
              stable       <= cand;
              level        <= enc(cand);
              level_update <= 1'b1;
              state        <= COMMIT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (s != cand) begin
            cand  <= s;
            cnt   <= '0;
            state <= DEBOUNCE;
          end else if (!game_busy) begin
            stable       <= cand;
            level        <= enc(cand);
            level_update <= 1'b1;
            state        <= COMMIT;
          end else begin
            pending <= 1'b1;
          end
        end
        COMMIT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_level_select_ctrl.sv
// Scoreboard bench for level_select_ctrl: expected commits (level, cycle) are queued
// at stimulus time and matched against each level_update pulse.
module tb_level_select_ctrl;

  localparam int unsigned N_SW    = 4;
  localparam int unsigned DEB     = 16;
  localparam int unsigned LEVEL_W = 3;

  logic               clk;
  logic               reset;
  logic [N_SW-1:0]    sw;
  logic               game_busy;
  logic [LEVEL_W-1:0] level;
  logic               level_update;
  logic               pending;

  typedef struct {
    logic [LEVEL_W-1:0] lvl;
    int unsigned        at;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic        prev_lu = 1'b0;

  level_select_ctrl #(.N_SW(N_SW), .DEB_CYCLES(DEB), .LEVEL_W(LEVEL_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .sw           (sw),
    .game_busy    (game_busy),
    .level        (level),
    .level_update (level_update),
    .pending      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  // Every pulse must be expected, single-cycle, on time and carry the right level.
  always @(negedge clk) begin
    if (level_update) begin
      if (prev_lu) check_eq("lu_consecutive", 32'd1, 32'd0);
      if (sb.size() == 0) begin
        check_eq("unexpected_pulse", 32'(level), 32'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("pulse_level", 32'(level), 32'(e.lvl));
        check_eq("pulse_time", cyc, e.at);
      end
    end
    prev_lu = level_update;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a switch vector; when a commit is due it lands DEB+3 edges later.
  task automatic drive_sw(input logic [N_SW-1:0] v, input bit exp_pulse, input logic [LEVEL_W-1:0] lvl);
    sw = v;
    if (exp_pulse) sb.push_back('{lvl, cyc + DEB + 3});
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 80) begin
      step(1);
      n++;
    end
    check_eq(tag, 32'(sb.size()), 32'd0);
    step(2);
  endtask

  initial begin
    reset     = 1'b1;
    sw        = 4'b0101;
    game_busy = 1'b0;

    // Reset holds all outputs low.
    for (int i = 0; i < 3; i++) begin
      step(2);
      check_eq("rst_level", 32'(level), 32'd0);
      check_eq("rst_lu", 32'(level_update), 32'd0);
      check_eq("rst_pending", 32'(pending), 32'd0);
    end

    // Switches already on at release commit normally.
    reset = 1'b0;
    sb.push_back('{3'd3, cyc + DEB + 3});
    drain("drain_post_reset");
    check_eq("post_reset_level", 32'(level), 32'd3);

    // Clean change from stable zero, then a long hold with no further pulses.
    drive_sw(4'b0000, 1'b1, 3'd0);
    drain("drain_clear");
    drive_sw(4'b0100, 1'b1, 3'd3);
    drain("drain_clean");
    step(40);
    check_eq("clean_level", 32'(level), 32'd3);
    drive_sw(4'b0000, 1'b1, 3'd0);
    drain("drain_clear2");

    // Short glitch is filtered.
    drive_sw(4'b0001, 1'b0, 3'd0);
    step(3);
    drive_sw(4'b0000, 1'b0, 3'd0);
    step(DEB + 10);
    check_eq("glitch_level", 32'(level), 32'd0);

    // Bouncing sw[1] restarts the debounce until it finally settles high.
    for (int i = 0; i < 8; i++) begin
      drive_sw(sw ^ 4'b0010, 1'b0, 3'd0);
      step(5);
    end
    drive_sw(4'b0010, 1'b1, 3'd2);
    drain("drain_bounce");
    check_eq("bounce_level", 32'(level), 32'd2);

    // Priority encoding.
    drive_sw(4'b1011, 1'b1, 3'd4);
    drain("drain_prio4");
    check_eq("prio_1011", 32'(level), 32'd4);
    drive_sw(4'b0011, 1'b1, 3'd2);
    drain("drain_prio2");
    check_eq("prio_0011", 32'(level), 32'd2);
    drive_sw(4'b0000, 1'b1, 3'd0);
    drain("drain_prio0");
    check_eq("prio_0000", 32'(level), 32'd0);

    // Change while the game is busy.
    game_busy = 1'b1;
    drive_sw(4'b0010, 1'b0, 3'd0);
    step(DEB + 2);
    check_eq("busy_pending_early", 32'(pending), 32'd0);
    step(6);
`ifdef LEVEL_LOCK_EN
    check_eq("busy_pending", 32'(pending), 32'd0);
    game_busy = 1'b0;
    step(10);
    check_eq("lock_level", 32'(level), 32'd0);
    check_eq("lock_pending", 32'(pending), 32'd0);
`else
    check_eq("busy_pending", 32'(pending), 32'd1);
    check_eq("busy_level_held", 32'(level), 32'd0);
    game_busy = 1'b0;
    sb.push_back('{3'd2, cyc + 1});
    drain("drain_busy");
    check_eq("busy_level", 32'(level), 32'd2);
    check_eq("busy_pending_clr", 32'(pending), 32'd0);
`endif

    // Asynchronous reset in the middle of a debounce (cnt reaches 7 ten edges in).
    drive_sw(4'b0100, 1'b0, 3'd0);
    step(10);
    reset = 1'b1;
    #1;
    check_eq("midrst_level", 32'(level), 32'd0);
    check_eq("midrst_lu", 32'(level_update), 32'd0);
    check_eq("midrst_pending", 32'(pending), 32'd0);
    step(2);
    reset = 1'b0;
    sb.push_back('{3'd3, cyc + DEB + 3});
    drain("drain_midrst");
    check_eq("midrst_relevel", 32'(level), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
